axis_frame_gate: RTL and testbench

Frame-aligned AXI-Stream gate and decimator placed in the video path beside the frame-rate monitor. On a start command it waits for a start-of-frame beat (`tuser[0]`), passes whole frames downstream, and optionally drops frames at a programmable ratio. It stops cleanly on a frame boundary after a programmed frame count or a stop request. Frames not passed are sunk upstream so the source never stalls.

---
 rtl/axis_frame_gate.sv | 145 ++++++++++++++
 tb/tb_axis_frame_gate.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gate.sv
// axis_frame_gate: frame-aligned AXI-Stream gate and decimator.
// Starts and stops on SOF boundaries; frames not forwarded are sunk.
module axis_frame_gate #(
    parameter int AXIS_DATA_WIDTH      = 8,
    parameter int AXIS_DATA_USER_WIDTH = 1,
    parameter int FRAME_COUNT_WIDTH    = 16,
    parameter int SKIP_WIDTH           = 8
) (
    input  logic                            i_axi_clk,
    input  logic                            i_axi_rst,
    input  logic                            i_start,
    input  logic                            i_stop,
    input  logic [FRAME_COUNT_WIDTH-1:0]    i_frame_count,
    input  logic [SKIP_WIDTH-1:0]           i_skip,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [31:0]                     o_frames_passed,
    output logic [31:0]                     o_frames_dropped,
    input  logic [AXIS_DATA_USER_WIDTH-1:0] i_axis_in_tuser,
    input  logic                            i_axis_in_tvalid,
    input  logic                            i_axis_in_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0]      i_axis_in_tdata,
    output logic                            o_axis_in_tready,
    output logic [AXIS_DATA_USER_WIDTH-1:0] o_axis_out_tuser,
    output logic                            o_axis_out_tvalid,
    output logic                            o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]      o_axis_out_tdata,
    input  logic                            i_axis_out_tready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        PASS,
        DROP
    } state_t;

    localparam logic [31:0] CNT_MAX = '1;

    state_t                       r_state;
    logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
    logic [SKIP_WIDTH-1:0]        r_skip;
    logic [SKIP_WIDTH-1:0]        r_skip_cnt;
    logic                         r_stop_pending;
    logic                         r_hold;
    logic [31:0]                  r_passed;
    logic [31:0]                  r_dropped;
    logic                         r_busy;
    logic                         r_done;

    logic w_sof;
    logic w_end;
    logic w_route_pass;

    // Frame decision at an SOF beat and resulting stream routing.
    // r_hold pins a stalled PASS-bound SOF so a late stop cannot
    // retract a beat already offered downstream.
    always_comb begin
        w_sof = (r_state != IDLE) && i_axis_in_tvalid
              && i_axis_in_tuser[0];
        w_end = !r_hold && (r_stop_pending
              || ((r_frame_count != '0)
                  && (r_passed == 32'(r_frame_count))));
        if (w_sof) begin
            w_route_pass = !w_end && (r_skip_cnt == '0);
        end else begin
            w_route_pass = (r_state == PASS);
        end
        o_axis_out_tvalid = w_route_pass && i_axis_in_tvalid;
        o_axis_in_tready  = w_route_pass ? i_axis_out_tready : 1'b1;
    end

    assign o_axis_out_tuser = i_axis_in_tuser;
    assign o_axis_out_tlast = i_axis_in_tlast;
    assign o_axis_out_tdata = i_axis_in_tdata;

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_frames_passed  = r_passed;
    assign o_frames_dropped = r_dropped;

    // Control FSM: start latch, per-SOF pass/drop/end decision, counters.
    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            r_state        <= IDLE;
            r_frame_count  <= '0;
            r_skip         <= '0;
            r_skip_cnt     <= '0;
            r_stop_pending <= 1'b0;
            r_hold         <= 1'b0;
            r_passed       <= '0;
            r_dropped      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy && i_stop) begin
                r_stop_pending <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state        <= WAIT_SOF;
                        r_busy         <= 1'b1;
                        r_frame_count  <= i_frame_count;
                        r_skip         <= i_skip;
                        r_skip_cnt     <= '0;
                        r_passed       <= '0;
                        r_dropped      <= '0;
                        r_stop_pending <= 1'b0;
                        r_hold         <= 1'b0;
                    end
                end
                default: begin
                    if (w_sof) begin
                        if (w_end) begin
                            r_state        <= IDLE;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_stop_pending <= 1'b0;
                        end else if (r_skip_cnt == '0) begin
                            if (i_axis_out_tready) begin
                                r_state    <= PASS;
                                r_skip_cnt <= r_skip;
                                r_hold     <= 1'b0;
                                if (r_passed != CNT_MAX) begin
                                    r_passed <= r_passed + 32'd1;
                                end
                            end else begin
                                r_hold <= 1'b1;
                            end
                        end else begin
                            r_state    <= DROP;
                            r_skip_cnt <= r_skip_cnt - SKIP_WIDTH'(1);
                            if (r_dropped != CNT_MAX) begin
                                r_dropped <= r_dropped + 32'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gate.sv
// tb_axis_frame_gate: table, hand-written and random checks of the
// frame gate against a frame-index arithmetic model.
`timescale 1ns/1ps
module tb_axis_frame_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] frame_count;
    logic [7:0]  skip;
    logic        busy;
    logic        done;
    logic [31:0] passed;
    logic [31:0] dropped;
    logic [0:0]  in_tuser;
    logic        in_tvalid;
    logic        in_tlast;
    logic [7:0]  in_tdata;
    logic        in_tready;
    logic [0:0]  out_tuser;
    logic        out_tvalid;
    logic        out_tlast;
    logic [7:0]  out_tdata;
    logic        out_tready;

    axis_frame_gate dut (
        .i_axi_clk         (clk),
        .i_axi_rst         (rst),
        .i_start           (start),
        .i_stop            (stop),
        .i_frame_count     (frame_count),
        .i_skip            (skip),
        .o_busy            (busy),
        .o_done            (done),
        .o_frames_passed   (passed),
        .o_frames_dropped  (dropped),
        .i_axis_in_tuser   (in_tuser),
        .i_axis_in_tvalid  (in_tvalid),
        .i_axis_in_tlast   (in_tlast),
        .i_axis_in_tdata   (in_tdata),
        .o_axis_in_tready  (in_tready),
        .o_axis_out_tuser  (out_tuser),
        .o_axis_out_tvalid (out_tvalid),
        .o_axis_out_tlast  (out_tlast),
        .o_axis_out_tdata  (out_tdata),
        .i_axis_out_tready (out_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int sk;
        int n;
        int lines;
        int pix;
        int exp_passed;
        int exp_dropped;
        int exp_done;
    } vec_t;

    int         n_cmp;
    int         n_bad;
    int         rdy_mode;
    logic [7:0] seq;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int         done_cnt = 0;
    int         gb;
    int         db;

    // Downstream monitor: record every handshaked beat and done cycle.
    always @(negedge clk) begin
        if (out_tvalid && out_tready) begin
            got_q.push_back({out_tuser, out_tlast, out_tdata});
        end
        if (done) begin
            done_cnt++;
        end
    end

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        out_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_tready = 1'b1;
            end else if (rdy_mode == 1) begin
                out_tready = 1'($urandom_range(0, 1));
            end else begin
                out_tready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_stream(input string nm);
        bit ok;
        int ng;
        ng = got_q.size() - gb;
        ok = (ng == exp_q.size());
        if (ok) begin
            foreach (exp_q[i]) begin
                if (got_q[gb + i] !== exp_q[i]) ok = 0;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d beats expected %0d beats, content differs",
                     nm, ng, exp_q.size());
        end
    endtask

    task automatic mark();
        exp_q.delete();
        gb = got_q.size();
        db = done_cnt;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        in_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mark();
    endtask

    task automatic pulse_start(input int cnt, input int sk);
        frame_count = 16'(cnt);
        skip        = 8'(sk);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Present one beat and hold it until the upstream handshake.
    task automatic send_beat(input logic [9:0] rec);
        bit ok;
        int t;
        in_tuser  = rec[9];
        in_tlast  = rec[8];
        in_tdata  = rec[7:0];
        in_tvalid = 1'b1;
        ok = 0;
        t  = 0;
        while (!ok && t < 500) begin
            @(negedge clk);
            if (in_tready) ok = 1;
            else t++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got tready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    // Send beats b0..b1-1 of a frame with pix pixels per line.
    task automatic send_range(input int pix, input int b0, input int b1,
                              input bit fw, input bit gap);
        logic [9:0] rec;
        for (int b = b0; b < b1; b++) begin
            rec = {(b == 0), (b % pix == pix - 1), seq};
            if (fw) exp_q.push_back(rec);
            send_beat(rec);
            seq++;
            if (gap && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Frame i (0-based from first SOF after start) is forwarded when
    // i is a multiple of skip+1 and before the ending SOF index.
    task automatic model(input int cnt, input int sk, input int n,
                         output int p, output int d, output int dn,
                         output int endi);
        endi = (cnt == 0) ? n + 1 : (cnt - 1) * (sk + 1) + 1;
        p = 0;
        d = 0;
        for (int i = 0; i < n && i < endi; i++) begin
            if (i % (sk + 1) == 0) p++;
            else d++;
        end
        dn = (n > endi) ? 1 : 0;
    endtask

    task automatic run_case(input int cnt, input int sk, input int n,
                            input int lines, input int pix,
                            input bit gap, input int rm,
                            output int p, output int d, output int dn);
        int endi;
        do_reset();
        rdy_mode = rm;
        model(cnt, sk, n, p, d, dn, endi);
        pulse_start(cnt, sk);
        for (int f = 0; f < n; f++) begin
            send_range(pix, 0, lines * pix,
                       (f < endi) && (f % (sk + 1) == 0), gap);
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_stream("stream");
        check("busy_end", busy, (dn != 0) ? 0 : 1);
    endtask

    initial begin
        vec_t vecs[7];
        int   p;
        int   d;
        int   dn;
        vecs[0] = '{0, 0, 3, 4, 8, 3, 0, 0};
        vecs[1] = '{2, 0, 3, 4, 8, 2, 0, 1};
        vecs[2] = '{0, 2, 7, 4, 8, 3, 4, 0};
        vecs[3] = '{3, 1, 7, 2, 4, 3, 2, 1};
        vecs[4] = '{1, 3, 4, 2, 4, 1, 0, 1};
        vecs[5] = '{0, 1, 5, 2, 3, 3, 2, 0};
        vecs[6] = '{2, 2, 6, 2, 3, 2, 2, 1};

        n_cmp       = 0;
        n_bad       = 0;
        seq         = '0;
        gb          = 0;
        db          = 0;
        rdy_mode    = 2;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        frame_count = '0;
        skip        = '0;
        in_tvalid   = 1'b1;
        in_tuser    = 1'b1;
        in_tlast    = 1'b0;
        in_tdata    = 8'h5a;

        // Reset values with a live SOF and a stalled sink.
        @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_passed", passed, 0);
        check("rst_dropped", dropped, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_in_tready", in_tready, 1);
        in_tvalid = 1'b0;
        rdy_mode  = 0;

        // Table of frame sequences with fixed expected counters.
        foreach (vecs[k]) begin
            run_case(vecs[k].cnt, vecs[k].sk, vecs[k].n,
                     vecs[k].lines, vecs[k].pix, 0, 0, p, d, dn);
            check($sformatf("tbl%0d_passed", k), passed,
                  vecs[k].exp_passed);
            check($sformatf("tbl%0d_dropped", k), dropped,
                  vecs[k].exp_dropped);
            check($sformatf("tbl%0d_done", k), done_cnt - db,
                  vecs[k].exp_done);
        end

        // Stop in IDLE ignored; start with stop in the same cycle.
        do_reset();
        pulse_stop();
        frame_count = 16'd1;
        skip        = 8'd0;
        start       = 1'b1;
        stop        = 1'b1;
        @(negedge clk);
        check("busy_before_edge", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("busy_rise", busy, 1);
        send_range(8, 0, 16, 1, 0);
        send_range(8, 0, 16, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_stream("startstop_stream");
        check("startstop_passed", passed, 1);
        check("startstop_done", done_cnt - db, 1);

        // Start in the middle of a frame.
        do_reset();
        send_range(8, 0, 3, 0, 0);
        pulse_start(0, 0);
        send_range(8, 3, 32, 0, 0);
        send_range(8, 0, 32, 1, 0);
        send_range(8, 0, 32, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_stream("midstart_stream");
        check("midstart_passed", passed, 2);
        check("midstart_busy", busy, 1);

        // Stop mid-frame under random backpressure.
        do_reset();
        rdy_mode = 1;
        pulse_start(0, 0);
        send_range(8, 0, 32, 1, 1);
        send_range(8, 0, 10, 1, 1);
        pulse_stop();
        send_range(8, 10, 32, 1, 1);
        send_range(8, 0, 32, 0, 1);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_stream("stop_bp_stream");
        check("stop_bp_passed", passed, 2);
        check("stop_bp_done", done_cnt - db, 1);
        check("stop_bp_busy", busy, 0);

        // Asynchronous reset between edges while passing.
        do_reset();
        pulse_start(0, 0);
        send_range(8, 0, 5, 1, 0);
        rdy_mode  = 2;
        in_tdata  = seq;
        in_tuser  = 1'b0;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        @(posedge clk);
        #2;
        check("arst_pre_tready", in_tready, 0);
        check("arst_pre_passed", passed, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_tvalid", out_tvalid, 0);
        check("arst_in_tready", in_tready, 1);
        check("arst_busy", busy, 0);
        check("arst_passed", passed, 0);
        in_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;
        mark();
        pulse_start(0, 0);
        send_range(8, 0, 16, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_stream("arst_after_stream");
        check("arst_after_passed", passed, 1);

        // Random configurations, geometry, gaps and backpressure.
        for (int it = 0; it < 25; it++) begin
            int cnt;
            int sk;
            int n;
            int lines;
            int pix;
            int rm;
            cnt   = $urandom_range(0, 3);
            sk    = $urandom_range(0, 3);
            n     = $urandom_range(1, 6);
            lines = $urandom_range(1, 3);
            pix   = $urandom_range(1, 4);
            rm    = $urandom_range(0, 1);
            run_case(cnt, sk, n, lines, pix, 1, rm, p, d, dn);
            check($sformatf("rnd%0d_passed", it), passed, p);
            check($sformatf("rnd%0d_dropped", it), dropped, d);
            check($sformatf("rnd%0d_done", it), done_cnt - db, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
